// File: rtl/instr_fetch_unit_pkg.sv
// Shared types and constants for the instruction fetch path and its neighbours
// (control decoder, benches).
package instr_fetch_unit_pkg;

  typedef enum logic [1:0] {
    S_BOOT = 2'b00,
    S_REQ  = 2'b01,
    S_HOLD = 2'b10
  } fetch_state_e;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_BNE  = 6'b000101;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_LUI  = 6'b001111;
  localparam logic [5:0] OP_SLTI = 6'b001010;

  // Word-scaled, sign-extended branch displacement.
  function automatic logic [31:0] br_offset(input logic [15:0] imm16);
    return {{14{imm16[15]}}, imm16, 2'b00};
  endfunction

endpackage

// File: rtl/instr_fetch_unit_if.sv
// Memory-port and decode-side signals of the fetch unit; master is the fetch
// unit, slave is the memory/decode environment.
interface instr_fetch_unit_if #(
  parameter int CNT_W = 32
);
  logic             imem_req;
  logic [31:0]      imem_addr;
  logic             imem_ack;
  logic [31:0]      imem_rdata;
  logic [31:0]      instr;
  logic             instr_valid;
  logic             instr_ready;
  logic [31:0]      pc;
  logic [31:0]      pc_plus4;
  logic             br_taken;
  logic [15:0]      br_imm16;
  logic             jmp;
  logic [25:0]      jmp_target26;
  logic [CNT_W-1:0] fetch_count;

  modport master (
    output imem_req, imem_addr, instr, instr_valid, pc, pc_plus4, fetch_count,
    input  imem_ack, imem_rdata, instr_ready, br_taken, br_imm16, jmp, jmp_target26
  );

  modport slave (
    input  imem_req, imem_addr, instr, instr_valid, pc, pc_plus4, fetch_count,
    output imem_ack, imem_rdata, instr_ready, br_taken, br_imm16, jmp, jmp_target26
  );

endinterface

// File: rtl/instr_fetch_unit_npc_calc.sv
// Next-PC selection from the redirect controls of the presented instruction.
// Jump wins over a taken branch; all arithmetic wraps at 32 bits.
module npc_calc
  import instr_fetch_unit_pkg::*;
(
  input  logic [31:0] pc_plus4_i,
  input  logic        br_taken_i,
  input  logic [15:0] br_imm16_i,
  input  logic        jmp_i,
  input  logic [25:0] jmp_target26_i,
  output logic [31:0] npc_o
);

  always_comb begin
    npc_o = pc_plus4_i;
    if (jmp_i) begin
      npc_o = {pc_plus4_i[31:28], jmp_target26_i, 2'b00};
    end else if (br_taken_i) begin
      npc_o = pc_plus4_i + br_offset(br_imm16_i);
    end
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: owns the PC, fetches one word at a time and holds
// it for decode until accepted.
//
// state  | meaning
// S_BOOT | first cycle after reset, no request yet
// S_REQ  | imem_req high at pc, waiting for imem_ack
// S_HOLD | instr valid, waiting for instr_ready
module instr_fetch_unit
  import instr_fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int          CNT_W    = 32
) (
  input logic                 clk,
  input logic                 rst,
  instr_fetch_unit_if.master  bus
);

  localparam logic [31:0] PC_INIT = {RESET_PC[31:2], 2'b00};

  fetch_state_e     state_q, state_d;
  logic [31:0]      pc_q, pc_d;
  logic [31:0]      instr_q, instr_d;
  logic             instr_valid_q, instr_valid_d;
  logic [CNT_W-1:0] fetch_count_q, fetch_count_d;
  logic             imem_req;
  logic [31:0]      pc_plus4;
  logic [31:0]      npc;

  assign pc_plus4 = pc_q + 32'd4;

  npc_calc u_npc_calc (
    .pc_plus4_i     (pc_plus4),
    .br_taken_i     (bus.br_taken),
    .br_imm16_i     (bus.br_imm16),
    .jmp_i          (bus.jmp),
    .jmp_target26_i (bus.jmp_target26),
    .npc_o          (npc)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= S_BOOT;
      pc_q          <= PC_INIT;
      instr_q       <= 32'h0;
      instr_valid_q <= 1'b0;
      fetch_count_q <= '0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      instr_q       <= instr_d;
      instr_valid_q <= instr_valid_d;
      fetch_count_q <= fetch_count_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    instr_d       = instr_q;
    instr_valid_d = instr_valid_q;
    fetch_count_d = fetch_count_q;
    imem_req      = 1'b0;
    case (state_q)
      S_BOOT: state_d = S_REQ;
      S_REQ: begin
        imem_req = 1'b1;
        if (bus.imem_ack) begin
          instr_d       = bus.imem_rdata;
          instr_valid_d = 1'b1;
          state_d       = S_HOLD;
        end
      end
      S_HOLD: begin
        // Redirect inputs only matter on the accepting cycle.
        if (bus.instr_ready) begin
          instr_valid_d = 1'b0;
          pc_d          = npc;
          fetch_count_d = fetch_count_q + CNT_W'(1);
          state_d       = S_REQ;
        end
      end
      default: state_d = S_BOOT;
    endcase
  end

  assign bus.imem_req    = imem_req;
  assign bus.imem_addr   = pc_q;
  assign bus.instr       = instr_q;
  assign bus.instr_valid = instr_valid_q;
  assign bus.pc          = pc_q;
  assign bus.pc_plus4    = pc_plus4;
  assign bus.fetch_count = fetch_count_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: table of fetch/redirect vectors plus
// hand sequences for reset abort and a jump from a high PC region.
module tb_instr_fetch_unit;
  import instr_fetch_unit_pkg::*;

  typedef struct {
    int          ack_delay;
    int          hold_delay;
    logic        bt;
    logic [15:0] imm;
    logic        j;
    logic [25:0] tgt;
    logic [31:0] addr;
  } fetch_vec_t;

  logic clk;
  logic rst;
  int   n_tests;
  int   n_fail;

  instr_fetch_unit_if #(.CNT_W(32)) bus_if ();
  instr_fetch_unit_if #(.CNT_W(32)) bus_hi ();

  instr_fetch_unit #(.RESET_PC(32'h0000_0000), .CNT_W(32)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  instr_fetch_unit #(.RESET_PC(32'h4000_0000), .CNT_W(32)) u_dut_hi (
    .clk (clk),
    .rst (rst),
    .bus (bus_hi)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    logic [5:0] op;
    case (a[4:2])
      3'd0:    op = OP_R;
      3'd1:    op = OP_LW;
      3'd2:    op = OP_SW;
      3'd3:    op = OP_BEQ;
      3'd4:    op = OP_BNE;
      3'd5:    op = OP_J;
      3'd6:    op = OP_LUI;
      default: op = OP_SLTI;
    endcase
    return {op, a[27:2]};
  endfunction

  assign bus_hi.imem_ack   = 1'b1;
  assign bus_hi.imem_rdata = mem_word(bus_hi.imem_addr);

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic junk_redirect();
    bus_if.br_taken     = 1'b1;
    bus_if.jmp          = 1'b1;
    bus_if.br_imm16     = 16'($urandom);
    bus_if.jmp_target26 = 26'($urandom);
  endtask

  task automatic do_fetch(input fetch_vec_t v, input int idx);
    chk($sformatf("v%0d req", idx), 32'(bus_if.imem_req), 32'd1);
    chk($sformatf("v%0d addr", idx), bus_if.imem_addr, v.addr);
    bus_if.imem_ack = 1'b0;
    bus_if.instr_ready = 1'b1;
    for (int c = 0; c < v.ack_delay; c++) begin
      step();
      chk($sformatf("v%0d wait%0d req", idx, c), 32'(bus_if.imem_req), 32'd1);
      chk($sformatf("v%0d wait%0d addr", idx, c), bus_if.imem_addr, v.addr);
      chk($sformatf("v%0d wait%0d valid", idx, c), 32'(bus_if.instr_valid), 32'd0);
    end
    bus_if.instr_ready = 1'b0;
    bus_if.imem_ack    = 1'b1;
    bus_if.imem_rdata  = mem_word(v.addr);
    step();
    chk($sformatf("v%0d valid", idx), 32'(bus_if.instr_valid), 32'd1);
    chk($sformatf("v%0d req_low", idx), 32'(bus_if.imem_req), 32'd0);
    chk($sformatf("v%0d instr", idx), bus_if.instr, mem_word(v.addr));
    chk($sformatf("v%0d pc", idx), bus_if.pc, v.addr);
    chk($sformatf("v%0d pc_plus4", idx), bus_if.pc_plus4, v.addr + 32'd4);
    // Stray acks and junk redirects while holding must change nothing.
    bus_if.imem_rdata = 32'hBAD0_0BAD;
    for (int c = 0; c < v.hold_delay; c++) begin
      junk_redirect();
      step();
      chk($sformatf("v%0d hold%0d valid", idx, c), 32'(bus_if.instr_valid), 32'd1);
      chk($sformatf("v%0d hold%0d req", idx, c), 32'(bus_if.imem_req), 32'd0);
      chk($sformatf("v%0d hold%0d instr", idx, c), bus_if.instr, mem_word(v.addr));
      chk($sformatf("v%0d hold%0d pc", idx, c), bus_if.pc, v.addr);
    end
    bus_if.imem_ack     = 1'b0;
    bus_if.instr_ready  = 1'b1;
    bus_if.br_taken     = v.bt;
    bus_if.br_imm16     = v.imm;
    bus_if.jmp          = v.j;
    bus_if.jmp_target26 = v.tgt;
    step();
    bus_if.instr_ready = 1'b0;
    junk_redirect();
    chk($sformatf("v%0d valid_low", idx), 32'(bus_if.instr_valid), 32'd0);
  endtask

  fetch_vec_t vec [14];
  logic [31:0] exp_cnt;

  initial begin
    vec[0]  = '{0, 0, 1'b0, 16'h0000, 1'b0, 26'h0,        32'h0000_0000};
    vec[1]  = '{0, 0, 1'b0, 16'h0000, 1'b0, 26'h0,        32'h0000_0004};
    vec[2]  = '{1, 0, 1'b0, 16'h0000, 1'b1, 26'h4,        32'h0000_0008};
    vec[3]  = '{3, 0, 1'b0, 16'h0000, 1'b0, 26'h0,        32'h0000_0010};
    vec[4]  = '{0, 1, 1'b0, 16'h0000, 1'b1, 26'h8,        32'h0000_0014};
    vec[5]  = '{0, 0, 1'b1, 16'hFFFE, 1'b0, 26'h0,        32'h0000_0020};
    vec[6]  = '{0, 0, 1'b0, 16'h0000, 1'b1, 26'h8,        32'h0000_001C};
    vec[7]  = '{2, 0, 1'b1, 16'h0003, 1'b0, 26'h0,        32'h0000_0020};
    vec[8]  = '{0, 0, 1'b0, 16'hFFFF, 1'b0, 26'h3FF_FFFF, 32'h0000_0030};
    vec[9]  = '{0, 0, 1'b1, 16'hFFFF, 1'b0, 26'h0,        32'h0000_0034};
    vec[10] = '{0, 0, 1'b1, 16'hFFF2, 1'b0, 26'h0,        32'h0000_0034};
    vec[11] = '{0, 0, 1'b1, 16'hFFFE, 1'b0, 26'h0,        32'h0000_0000};
    vec[12] = '{0, 5, 1'b0, 16'h0000, 1'b0, 26'h0,        32'hFFFF_FFFC};
    vec[13] = '{0, 0, 1'b0, 16'h0000, 1'b0, 26'h0,        32'h0000_0000};

    n_tests = 0;
    n_fail  = 0;
    exp_cnt = 32'd0;
    rst = 1'b1;
    bus_if.imem_ack     = 1'b0;
    bus_if.imem_rdata   = 32'h0;
    bus_if.instr_ready  = 1'b0;
    bus_if.br_taken     = 1'b0;
    bus_if.br_imm16     = 16'h0;
    bus_if.jmp          = 1'b0;
    bus_if.jmp_target26 = 26'h0;
    bus_hi.instr_ready  = 1'b0;
    bus_hi.br_taken     = 1'b0;
    bus_hi.br_imm16     = 16'h0;
    bus_hi.jmp          = 1'b0;
    bus_hi.jmp_target26 = 26'h0;

    repeat (2) @(posedge clk);
    #1;
    chk("rst req", 32'(bus_if.imem_req), 32'd0);
    chk("rst valid", 32'(bus_if.instr_valid), 32'd0);
    chk("rst instr", bus_if.instr, 32'h0);
    chk("rst pc", bus_if.pc, 32'h0);
    chk("rst pc_plus4", bus_if.pc_plus4, 32'h4);
    chk("rst count", bus_if.fetch_count, 32'h0);
    chk("rst hi pc", bus_hi.pc, 32'h4000_0000);

    rst = 1'b0;
    chk("boot req", 32'(bus_if.imem_req), 32'd0);
    step();
    chk("first req", 32'(bus_if.imem_req), 32'd1);
    chk("first valid", 32'(bus_if.instr_valid), 32'd0);

    for (int i = 0; i < 14; i++) begin
      do_fetch(vec[i], i);
      exp_cnt = exp_cnt + 32'd1;
      chk($sformatf("v%0d count", i), bus_if.fetch_count, exp_cnt);
    end
    chk("post wrap addr", bus_if.imem_addr, 32'h0000_0004);
    chk("post wrap req", 32'(bus_if.imem_req), 32'd1);

    // High-region instance has been parked in S_HOLD at its reset PC.
    chk("hi valid", 32'(bus_hi.instr_valid), 32'd1);
    chk("hi pc", bus_hi.pc, 32'h4000_0000);
    chk("hi instr", bus_hi.instr, mem_word(32'h4000_0000));
    bus_hi.instr_ready  = 1'b1;
    bus_hi.jmp          = 1'b1;
    bus_hi.br_taken     = 1'b1;
    bus_hi.br_imm16     = 16'h0040;
    bus_hi.jmp_target26 = 26'h000_0040;
    step();
    bus_hi.instr_ready = 1'b0;
    chk("hi jump addr", bus_hi.imem_addr, 32'h4000_0100);
    chk("hi jump req", 32'(bus_hi.imem_req), 32'd1);
    chk("hi count", bus_hi.fetch_count, 32'd1);
    chk("main ack pending req", 32'(bus_if.imem_req), 32'd1);
    chk("main ack pending addr", bus_if.imem_addr, 32'h0000_0004);

    #2;
    rst = 1'b1;
    #1;
    chk("abort req", 32'(bus_if.imem_req), 32'd0);
    chk("abort valid", 32'(bus_if.instr_valid), 32'd0);
    chk("abort instr", bus_if.instr, 32'h0);
    chk("abort pc", bus_if.pc, 32'h0);
    chk("abort count", bus_if.fetch_count, 32'h0);
    chk("abort hi pc", bus_hi.pc, 32'h4000_0000);
    step();
    rst = 1'b0;
    bus_if.imem_ack   = 1'b1;
    bus_if.imem_rdata = 32'hDEAD_BEEF;
    step();
    bus_if.imem_ack = 1'b0;
    chk("stray ack valid", 32'(bus_if.instr_valid), 32'd0);
    chk("stray ack instr", bus_if.instr, 32'h0);
    chk("restart req", 32'(bus_if.imem_req), 32'd1);
    chk("restart addr", bus_if.imem_addr, 32'h0);
    do_fetch('{0, 0, 1'b0, 16'h0000, 1'b0, 26'h0, 32'h0000_0000}, 99);
    chk("restart next addr", bus_if.imem_addr, 32'h0000_0004);
    chk("restart count", bus_if.fetch_count, 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
- Producer end of the opcode/control interface: fetches 32-bit instruction words from instruction memory and presents them, one at a time, to the decode/control stage through a valid/ready handshake.
- Owns the PC register. Computes the next PC from the redirect controls (Branch-taken, Jump) that the control/execute path returns for the instruction currently presented.
- Sits between the instruction memory port and the opcode decoder.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded at reset; bits [1:0] must be 0.
CNT_W, 32, width of the accepted-instruction counter.

Ports:
clk  input  1  system clock, all state on rising edge
rst  input  1  asynchronous, active-high reset
imem_req  output  1  fetch request to instruction memory
imem_addr  output  32  fetch address (equals pc while imem_req=1)
imem_ack  input  1  memory response strobe; imem_rdata valid this cycle
imem_rdata  input  32  instruction word from memory
instr  output  32  registered instruction presented to decode
instr_valid  output  1  instr holds a fetched, not-yet-accepted word
instr_ready  input  1  decode/execute accepts instr this cycle
pc  output  32  address of the word in instr
pc_plus4  output  32  pc + 4 (mod 2^32)
br_taken  input  1  branch resolved taken for the presented instr (Branch AND condition)
br_imm16  input  16  branch immediate of the presented instr
jmp  input  1  presented instr is a jump
jmp_target26  input  26  jump target field
fetch_count  output  CNT_W  number of accepted instructions, wraps

Behaviour:
- Reset (async, asserted): state=S_BOOT, pc=RESET_PC, imem_req=0, instr=0, instr_valid=0, fetch_count=0. Reset mid-transaction abandons it; a late imem_ack after reset is ignored unless state=S_REQ.
- States:
  - S_BOOT: one cycle after reset release -> S_REQ.
  - S_REQ: imem_req=1, imem_addr=pc, both held stable until imem_ack. On imem_ack: instr<=imem_rdata, instr_valid<=1 -> S_HOLD. imem_ack in the first S_REQ cycle (zero-wait memory) is legal.
  - S_HOLD: imem_req=0, instr_valid=1, instr/pc stable. On instr_ready: instr_valid<=0, pc<=npc, fetch_count<=fetch_count+1 -> S_REQ. Otherwise remain.
- imem_ack outside S_REQ is ignored. instr_ready outside S_HOLD is ignored.
- br_taken, br_imm16, jmp and jmp_target26 are sampled only on the accepting cycle (S_HOLD & instr_ready). They are don't-care at all other times.
- npc:
  - jmp=1: {pc_plus4[31:28], jmp_target26, 2'b00}. jmp has priority over br_taken.
  - else br_taken=1: pc_plus4 + {{14{br_imm16[15]}}, br_imm16, 2'b00}, 32-bit modulo.
  - else: pc_plus4.
- PC arithmetic is 32-bit wrap-around: pc=32'hFFFF_FFFC sequential -> 32'h0000_0000. pc[1:0] is always 0.
- Throughput and latency:
  - Minimum 2 cycles per instruction (S_REQ with immediate ack, then S_HOLD with immediate ready).
  - Latency from req assertion to instr_valid = ack wait + 1.
- fetch_count wraps at 2^CNT_W. Not cleared except by reset.

Decomposition:
- Shared package:
  - fetch state encoding (S_BOOT, S_REQ, S_HOLD, 2 bits)
  - RESET_PC default
  - opcode constants (R=6'b000000, LW=6'b100011, SW=6'b101011, BEQ=6'b000100, BNE=6'b000101, J=6'b000010, LUI=6'b001111, SLTI=6'b001010), shared with the control decoder and benches
- One combinational sub-module, npc_calc (inputs pc_plus4, br_taken, br_imm16, jmp, jmp_target26; output npc). Keeps next-PC logic testable in isolation.

Test Plan:
- Reset release, zero-wait memory, instr_ready tied 1 -> imem_addr 0x0,0x4,0x8 on alternate cycles; fetch_count 1,2,3; first instr_valid 2 cycles after S_BOOT.
- Memory ack delayed 3 cycles at pc=0x10 -> imem_req and imem_addr=0x10 held stable 3 cycles; instr_valid rises the cycle after ack; instr=imem_rdata captured.
- Accept at pc=0x20 with br_taken=1, br_imm16=16'hFFFE -> next imem_addr=0x1C. Repeat with br_imm16=16'h0003 -> 0x30.
- Accept at pc=0x4000_0000 with jmp=1, br_taken=1, jmp_target26=26'h000_0040 -> next imem_addr=0x4000_0100 (jump wins).
- pc=0xFFFF_FFFC, sequential accept -> next imem_addr=0x0000_0000. Hold instr_ready=0 for 5 cycles in S_HOLD -> instr, pc and instr_valid stable, no imem_req.
- Assert rst during S_REQ while ack is pending, then deliver a stray ack in S_BOOT -> outputs return to reset values immediately; stray ack ignored; fetch restarts at RESET_PC.
